id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register of the 5-stage MIPS core, with load-use hazard detection and forwarding-select generation.
- Captures decoded operands and control from ID.
- Inserts bubbles on load-use stall or branch flush.
- Drives the 2-bit select inputs of the EX-stage 4:1 operand muxes: ALU A and ALU B/immediate.

Parameters:
DATA_W, 32, operand/immediate width
REG_ADDR_W, 5, register-index width
CTRL_W, 8, opaque EX/MEM/WB control bundle width

Ports:
clk  in  1  core clock, rising edge
rst  in  1  synchronous reset, active-high
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_ADDR_W  source A index
id_rt  in  REG_ADDR_W  source B index
id_rd  in  REG_ADDR_W  resolved destination index
id_rs_data  in  DATA_W  regfile read A
id_rt_data  in  DATA_W  regfile read B
id_imm  in  DATA_W  extended immediate
id_ctrl  in  CTRL_W  control bundle
id_reads_rt  in  1  instruction uses rt as ALU source (else immediate)
id_mem_read  in  1  instruction is a load
id_reg_write  in  1  instruction writes a register
flush  in  1  branch/jump taken; squash ID
exmem_reg_write  in  1  EX/MEM writes a register
exmem_rd  in  REG_ADDR_W  EX/MEM destination
memwb_reg_write  in  1  MEM/WB writes a register
memwb_rd  in  REG_ADDR_W  MEM/WB destination
stall  out  1  hold PC and IF/ID (combinational)
ex_valid  out  1  EX holds a real instruction
ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered operands
ex_rs, ex_rt, ex_rd  out  REG_ADDR_W  registered indices
ex_ctrl  out  CTRL_W  registered control
ex_mem_read, ex_reg_write  out  1  registered, forced 0 in a bubble
fwd_a_sel  out  2  ALU-A mux select
fwd_b_sel  out  2  ALU-B mux select

Behaviour:
- Registers: all ex_* outputs are registered.
  - rst=1 at a clk edge: every registered output <= 0.
  - Consequences: ex_valid=0, fwd sels=00, stall=0.
- Stall (combinational):
  - stall = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & !flush & ((ex_rd==id_rs) | (id_reads_rt & ex_rd==id_rt)).
- Capture, per edge with rst=0:
  - flush|stall: bubble. ex_valid, ex_mem_read, ex_reg_write, ex_ctrl, all indices and data <= 0.
  - otherwise: all id_* values captured. ex_valid <= id_valid. ex_mem_read and ex_reg_write are gated by id_valid.
  - Flush and stall together: bubble once; stall is masked by flush.
- Latency: exactly 1 cycle ID to EX. A stall inserts exactly one bubble; the load then reaches MEM and the stall drops.
- fwd_a_sel, combinational from registered ex_rs, priority order:
  - ex_valid=0: 00.
  - exmem_reg_write & exmem_rd!=0 & exmem_rd==ex_rs: 01.
  - memwb_reg_write & memwb_rd!=0 & memwb_rd==ex_rs: 10.
  - else: 00.
- fwd_b_sel:
  - ex_valid & !ex_reads_rt (internal registered bit): 11 (immediate).
  - otherwise: same rule as A, applied to ex_rt.
- Select encoding: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 immediate.
- Register 0 is never forwarded. Source register 0 never causes a stall.
- Reset mid-stall: reset wins. The next cycle has stall=0 and is bubble-free.

Optional Feature:
Macro: IDEX_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cnt[31:0] and flush_cnt[31:0], reset to 0 by rst.
  - stall_cnt increments on every edge with stall=1 (stall is already 0 whenever flush=1).
  - flush_cnt increments on flush=1.
  - Both wrap at 2^32-1 -> 0.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg:
  - FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_IMM=2'b11.
  - REG_ZERO=0.
  - Width constants DATA_W, REG_ADDR_W, CTRL_W.
- Sub-module fwd_sel_gen: combinational priority compare of one source index against EX/MEM and MEM/WB.
  - Instantiated twice, for A and B.
  - B's immediate override stays in id_ex_stage.

Test Plan:
1. rst=1 for 2 cycles with random id_* inputs -> all ex_* = 0, fwd sels 00, stall=0.
2. Load-use:
   - Stimulus: lw r8 in EX (ex_mem_read=1, ex_rd=8), ID add rs=8, id_valid=1.
   - Required: stall=1 that cycle, next ex_valid=0.
   - Following cycle: stall=0 and add is captured.
3. Forwarding:
   - Both stages hit: ex_rs=5, ex_rt=5, id_reads_rt=1, exmem_rd=5 and memwb_rd=5, both reg_write=1 -> fwd_a_sel=01, fwd_b_sel=01 (EX/MEM priority).
   - EX/MEM disabled: exmem_reg_write=0 -> fwd_a_sel=10, fwd_b_sel=10.
4. Register 0: exmem_rd=0, exmem_reg_write=1, ex_rs=0 -> fwd_a_sel=00. Load with ex_rd=0 against id_rs=0 -> stall=0.
5. Flush with stall: flush=1 with load-use condition present -> stall=0, one bubble (ex_valid=0, ex_reg_write=0).
6. Immediate: id_reads_rt=0, id_imm=0x0000FFFC -> next cycle fwd_b_sel=11, ex_imm=0x0000FFFC. With IDEX_PERF_CNT_EN defined, the test-2 sequence -> stall_cnt=1.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the ID/EX pipeline register and its
// forwarding-select generators.
//   - Default widths for data, register index and control bundle.
//   - Encodings of the EX-stage operand mux selects.
//   - Index of the hard-wired zero register.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 8;

  // EX operand mux select encoding
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_IMM   = 2'b11;

  // Register 0 always reads as zero, so it never forwards or stalls
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/fwd_sel_gen.sv
// fwd_sel_gen: forwarding select for one EX source operand.
// Compares the registered source index against the EX/MEM and MEM/WB
// destinations; the younger (EX/MEM) result wins when both match.
// Ports:
//   valid           in  EX holds a real instruction
//   src             in  registered source register index
//   exmem_reg_write in  EX/MEM writes a register
//   exmem_rd        in  EX/MEM destination index
//   memwb_reg_write in  MEM/WB writes a register
//   memwb_rd        in  MEM/WB destination index
//   sel             out 2-bit mux select (FWD_REG/FWD_EXMEM/FWD_MEMWB)
module fwd_sel_gen #(
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
  input  logic                  valid,
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  output logic [1:0]            sel
);
  import mips_pkg::*;

  localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(REG_ZERO);

  // Priority compare: EX/MEM before MEM/WB, register 0 excluded
  always_comb begin
    sel = FWD_REG;
    if (!valid) begin
      sel = FWD_REG;
    end else if (exmem_reg_write && (exmem_rd != ZERO_IDX) && (exmem_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (memwb_reg_write && (memwb_rd != ZERO_IDX) && (memwb_rd == src)) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_REG;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage MIPS core.
// Captures ID operands/control, inserts a bubble on load-use stall or
// branch flush, and drives the EX operand mux selects.
// Ports:
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   id_*                       decoded instruction from ID
//   flush                      branch/jump taken, squash ID
//   exmem_*, memwb_*           downstream destinations for forwarding
//   stall                      combinational hold of PC and IF/ID
//   ex_*                       registered EX-stage operands/control
//   fwd_a_sel, fwd_b_sel       ALU A / ALU B mux selects (combinational)
// Optional build macro IDEX_PERF_CNT_EN adds stall_cnt and flush_cnt
// 32-bit wrapping event counters.
module id_ex_stage #(
  parameter int DATA_W     = mips_pkg::DATA_W,
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
  parameter int CTRL_W     = mips_pkg::CTRL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic                  id_reads_rt,
  input  logic                  id_mem_read,
  input  logic                  id_reg_write,
  input  logic                  flush,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_rs_data,
  output logic [DATA_W-1:0]     ex_rt_data,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic                  ex_mem_read,
  output logic                  ex_reg_write,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);
  import mips_pkg::*;

  localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(REG_ZERO);

  logic       ex_reads_rt_r;
  logic       stall_s;
  logic [1:0] a_sel_s;
  logic [1:0] b_sel_s;

  // Load-use hazard: the load in EX targets a register ID is about to read.
  // A flush squashes ID anyway, so it masks the stall.
  always_comb begin
    stall_s = 1'b0;
    if (id_valid && ex_valid && ex_mem_read && (ex_rd != ZERO_IDX) && !flush) begin
      stall_s = (ex_rd == id_rs) || (id_reads_rt && (ex_rd == id_rt));
    end else begin
      stall_s = 1'b0;
    end
  end

  assign stall = stall_s;

  // Pipeline register: reset, bubble on flush/stall, else capture ID
  always_ff @(posedge clk) begin
    if (rst || flush || stall_s) begin
      ex_valid      <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_reads_rt_r <= 1'b0;
      ex_ctrl       <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
    end else begin
      ex_valid      <= id_valid;
      ex_mem_read   <= id_mem_read && id_valid;
      ex_reg_write  <= id_reg_write && id_valid;
      ex_reads_rt_r <= id_reads_rt;
      ex_ctrl       <= id_ctrl;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_rd         <= id_rd;
      ex_rs_data    <= id_rs_data;
      ex_rt_data    <= id_rt_data;
      ex_imm        <= id_imm;
    end
  end

  fwd_sel_gen #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .valid           (ex_valid),
    .src             (ex_rs),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .sel             (a_sel_s)
  );

  fwd_sel_gen #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .valid           (ex_valid),
    .src             (ex_rt),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .sel             (b_sel_s)
  );

  assign fwd_a_sel = a_sel_s;

  // ALU B takes the immediate whenever the instruction does not read rt
  always_comb begin
    fwd_b_sel = FWD_REG;
    if (ex_valid && !ex_reads_rt_r) begin
      fwd_b_sel = FWD_IMM;
    end else begin
      fwd_b_sel = b_sel_s;
    end
  end

`ifdef IDEX_PERF_CNT_EN
  // Event counters, wrapping naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (stall_s) begin
        stall_cnt <= stall_cnt + 32'd1;
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (flush) begin
        flush_cnt <= flush_cnt + 32'd1;
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage.
// Each captured EX state is predicted when the ID inputs are presented and
// queued; a monitor pops and compares it one cycle later. Scenario tasks
// check stall and forwarding selects inline.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic        mem_read;
    logic        reg_write;
    logic        reads_rt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [7:0]  ctrl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_reads_rt, id_mem_read, id_reg_write, flush;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [7:0]  id_ctrl;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        stall, ex_valid, ex_mem_read, ex_reg_write;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [7:0]  ex_ctrl;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];
  exp_t m;          // model of the current EX contents
  exp_t mon_e, mon_a;
  int   exp_sc = 0;
  int   exp_fc = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .id_reads_rt(id_reads_rt),
    .id_mem_read(id_mem_read), .id_reg_write(id_reg_write), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .stall(stall),
    .ex_valid(ex_valid), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
`ifdef IDEX_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // Scoreboard monitor: compare EX registers just after each edge
  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      mon_a.valid = ex_valid;       mon_a.mem_read = ex_mem_read;
      mon_a.reg_write = ex_reg_write; mon_a.reads_rt = mon_e.reads_rt;
      mon_a.rs = ex_rs; mon_a.rt = ex_rt; mon_a.rd = ex_rd;
      mon_a.rs_data = ex_rs_data; mon_a.rt_data = ex_rt_data;
      mon_a.imm = ex_imm; mon_a.ctrl = ex_ctrl;
      tests++;
      if (mon_a !== mon_e) begin
        fails++;
        $display("FAIL ex_regs t=%0t got v%0b mr%0b rw%0b rs%0d rt%0d rd%0d a=%h b=%h i=%h c=%h want v%0b mr%0b rw%0b rs%0d rt%0d rd%0d a=%h b=%h i=%h c=%h",
                 $time, mon_a.valid, mon_a.mem_read, mon_a.reg_write, mon_a.rs, mon_a.rt, mon_a.rd,
                 mon_a.rs_data, mon_a.rt_data, mon_a.imm, mon_a.ctrl,
                 mon_e.valid, mon_e.mem_read, mon_e.reg_write, mon_e.rs, mon_e.rt, mon_e.rd,
                 mon_e.rs_data, mon_e.rt_data, mon_e.imm, mon_e.ctrl);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic model_stall();
    return id_valid && m.valid && m.mem_read && (m.rd != 5'd0) && !flush &&
           ((m.rd == id_rs) || (id_reads_rt && (m.rd == id_rt)));
  endfunction

  function automatic logic [1:0] model_sel(input logic [4:0] src);
    if (!m.valid) return 2'b00;
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == src) return 2'b01;
    if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [1:0] model_sel_b();
    if (m.valid && !m.reads_rt) return 2'b11;
    return model_sel(m.rt);
  endfunction

  // Predict the next EX state, queue it, and advance one clock
  task automatic tick();
    exp_t e;
    logic st;
    st = model_stall();
    e = '0;
    if (rst) begin
      exp_sc = 0;
      exp_fc = 0;
    end else begin
      if (st) exp_sc++;
      if (flush) exp_fc++;
      if (!(flush || st)) begin
        e.valid = id_valid;
        e.mem_read = id_mem_read && id_valid;
        e.reg_write = id_reg_write && id_valid;
        e.reads_rt = id_reads_rt;
        e.rs = id_rs; e.rt = id_rt; e.rd = id_rd;
        e.rs_data = id_rs_data; e.rt_data = id_rt_data;
        e.imm = id_imm; e.ctrl = id_ctrl;
      end
    end
    sb_q.push_back(e);
    m = e;
    @(posedge clk);
    #2;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic rrt, input logic mr, input logic rw);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_reads_rt = rrt;
    id_mem_read = mr; id_reg_write = rw;
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_ctrl = 8'($urandom);
  endtask

  task automatic clear_fwd();
    exmem_reg_write = 1'b0; exmem_rd = 5'd0;
    memwb_reg_write = 1'b0; memwb_rd = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; clear_fwd();
    for (int i = 0; i < 2; i++) begin
      set_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    rst = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    #1;
    tests++;
    if (stall !== 1'b0 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      fails++;
      $display("FAIL reset_outputs got stall=%0b a=%b b=%b want 0 00 00", stall, fwd_a_sel, fwd_b_sel);
    end
  endtask

  task automatic test_load_use();
    set_id(1'b1, 5'd1, 5'd2, 5'd8, 1'b0, 1'b1, 1'b1);   // lw r8
    tick();
    set_id(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 1'b1);  // add r10, r8, r9
    #1;
    tests++;
    if (stall !== 1'b1) begin
      fails++; $display("FAIL load_use_stall got %0b want 1", stall);
    end
    tick();                                             // bubble
    tests++;
    if (stall !== 1'b0) begin
      fails++; $display("FAIL load_use_release got %0b want 0", stall);
    end
    tick();                                             // add captured
`ifdef IDEX_PERF_CNT_EN
    tests++;
    if (stall_cnt !== 32'd1) begin
      fails++; $display("FAIL stall_cnt_one got %0d want 1", stall_cnt);
    end
`endif
  endtask

  task automatic test_forwarding();
    set_id(1'b1, 5'd5, 5'd5, 5'd7, 1'b1, 1'b0, 1'b1);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    exmem_reg_write = 1'b1; exmem_rd = 5'd5; memwb_reg_write = 1'b1; memwb_rd = 5'd5;
    #1;
    tests++;
    if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01) begin
      fails++; $display("FAIL fwd_both got a=%b b=%b want 01 01", fwd_a_sel, fwd_b_sel);
    end
    exmem_reg_write = 1'b0;
    #1;
    tests++;
    if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b10) begin
      fails++; $display("FAIL fwd_memwb got a=%b b=%b want 10 10", fwd_a_sel, fwd_b_sel);
    end
    memwb_rd = 5'd6;
    #1;
    tests++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      fails++; $display("FAIL fwd_none got a=%b b=%b want 00 00", fwd_a_sel, fwd_b_sel);
    end
    clear_fwd();
  endtask

  task automatic test_reg_zero();
    set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1);
    tick();
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_reg_write = 1'b1; memwb_rd = 5'd0;
    #1;
    tests++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      fails++; $display("FAIL fwd_reg0 got a=%b b=%b want 00 00", fwd_a_sel, fwd_b_sel);
    end
    clear_fwd();
    set_id(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b1, 1'b1);   // lw r0
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1);
    #1;
    tests++;
    if (stall !== 1'b0) begin
      fails++; $display("FAIL stall_reg0 got %0b want 0", stall);
    end
    tick();
  endtask

  task automatic test_flush_with_stall();
    set_id(1'b1, 5'd1, 5'd2, 5'd8, 1'b0, 1'b1, 1'b1);   // lw r8
    tick();
    set_id(1'b1, 5'd2, 5'd8, 5'd11, 1'b1, 1'b0, 1'b1);  // uses r8 via rt
    flush = 1'b1;
    #1;
    tests++;
    if (stall !== 1'b0) begin
      fails++; $display("FAIL flush_masks_stall got %0b want 0", stall);
    end
    tick();                                             // single bubble
    flush = 1'b0;
    tests++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
      fails++; $display("FAIL flush_bubble got v=%0b rw=%0b want 0 0", ex_valid, ex_reg_write);
    end
    set_id(1'b1, 5'd3, 5'd8, 5'd12, 1'b1, 1'b0, 1'b1);
    #1;
    tests++;
    if (stall !== 1'b0) begin
      fails++; $display("FAIL post_flush_stall got %0b want 0", stall);
    end
    tick();
  endtask

  task automatic test_immediate();
    set_id(1'b1, 5'd2, 5'd9, 5'd9, 1'b0, 1'b0, 1'b1);
    id_imm = 32'h0000FFFC;
    tick();
    tests++;
    if (fwd_b_sel !== 2'b11 || ex_imm !== 32'h0000FFFC) begin
      fails++; $display("FAIL immediate got b=%b imm=%h want 11 0000fffc", fwd_b_sel, ex_imm);
    end
  endtask

  task automatic test_reset_mid_stall();
    set_id(1'b1, 5'd1, 5'd2, 5'd8, 1'b0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd8, 5'd0, 5'd13, 1'b0, 1'b0, 1'b1);
    #1;
    tests++;
    if (stall !== 1'b1) begin
      fails++; $display("FAIL pre_reset_stall got %0b want 1", stall);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (stall !== 1'b0) begin
      fails++; $display("FAIL post_reset_stall got %0b want 0", stall);
    end
    tick();                                             // ID captured, no bubble
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom));
      flush = ($urandom_range(0, 7) == 0);
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3));
      memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3));
      #1;
      tests++;
      if (stall !== model_stall() || fwd_a_sel !== model_sel(m.rs) || fwd_b_sel !== model_sel_b()) begin
        fails++;
        $display("FAIL random_comb i=%0d got s=%0b a=%b b=%b want s=%0b a=%b b=%b",
                 i, stall, fwd_a_sel, fwd_b_sel, model_stall(), model_sel(m.rs), model_sel_b());
      end
      tick();
    end
    flush = 1'b0;
    clear_fwd();
  endtask

  task automatic test_perf();
`ifdef IDEX_PERF_CNT_EN
    tests++;
    if (stall_cnt !== 32'(exp_sc) || flush_cnt !== 32'(exp_fc)) begin
      fails++;
      $display("FAIL perf_counts got s=%0d f=%0d want s=%0d f=%0d", stall_cnt, flush_cnt, exp_sc, exp_fc);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    clear_fwd();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    m = '0;
    #2;
    test_reset();
    test_load_use();
    test_forwarding();
    test_reg_zero();
    test_flush_with_stall();
    test_immediate();
    test_reset_mid_stall();
    test_back_to_back();
    test_perf();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
